// File: rtl/key_pkg.sv
// ----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key click decoder:
//   state_t          - FSM state encoding (ST_IDLE / ST_COLLECT)
//   KEY_WIN_DEFAULT  - default inactivity window (10 ms at 50 MHz)
//   KEY_WIN_W        - width of the window timer
//   KEY_CNT_W        - width of the click count
// ----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam int          KEY_WIN_W       = 20;
    localparam int          KEY_CNT_W       = 2;
    localparam logic [19:0] KEY_WIN_DEFAULT = 20'd500_000;

endpackage

// File: rtl/key_click_decoder.sv
// ----------------------------------------------------------------------------
// key_click_decoder
// Groups the one-cycle press pulses from the key debouncer into single,
// double and triple click events. A group stays open while presses keep
// arriving within WIN_CYCLES of each other; one event is emitted per group,
// either when the window expires or as soon as MAX_CLICKS presses are seen.
//
// Parameters:
//   WIN_CYCLES  - inactivity window in sys_clk cycles (2 .. 2^20-1)
//   MAX_CLICKS  - count at which the event is emitted immediately (1..3)
// Ports:
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-high reset
//   key_pulse    in   one-cycle press pulse from the debouncer
//   click_valid  out  one-cycle event strobe (registered)
//   click_cnt    out  clicks in the group; valid with click_valid, held after
//   busy         out  high while a click group is open
// ----------------------------------------------------------------------------
module key_click_decoder
    import key_pkg::*;
#(
    parameter logic [KEY_WIN_W-1:0] WIN_CYCLES = KEY_WIN_DEFAULT,
    parameter logic [KEY_CNT_W-1:0] MAX_CLICKS = 2'd3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 key_pulse,
    output logic                 click_valid,
    output logic [KEY_CNT_W-1:0] click_cnt,
    output logic                 busy
);

    localparam logic [KEY_WIN_W-1:0] WIN_LAST = WIN_CYCLES - 20'd1;

    state_t                 state;
    logic [KEY_CNT_W-1:0]   cnt;
    logic [KEY_WIN_W-1:0]   win_cnt;

    // Decode of the current cycle, shared by the state and output registers
    // so both always agree on when an event fires.
    logic [KEY_CNT_W-1:0]   cnt_inc;
    logic                   idle_pulse;
    logic                   collect_pulse;
    logic                   emit_now;
    logic                   emit_max;
    logic                   timeout;
    logic                   emit;
    logic [KEY_CNT_W-1:0]   emit_cnt;

    assign cnt_inc       = cnt + 2'd1;
    assign idle_pulse    = (state == ST_IDLE)    && key_pulse;
    assign collect_pulse = (state == ST_COLLECT) && key_pulse;

    // MAX_CLICKS==1 turns every press into an immediate single-click event.
    assign emit_now = idle_pulse && (MAX_CLICKS == 2'd1);
    assign emit_max = collect_pulse && (cnt_inc == MAX_CLICKS);

    // A press in the last window cycle takes priority over the timeout:
    // timeout is qualified with !key_pulse.
    assign timeout  = (state == ST_COLLECT) && !key_pulse && (win_cnt == WIN_LAST);

    assign emit     = emit_now || emit_max || timeout;
    assign emit_cnt = timeout  ? cnt :
                      emit_now ? 2'd1 :
                                 cnt_inc;

    assign busy = (state == ST_COLLECT);

    // State, click count and window timer.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            win_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_pulse && !emit_now) begin
                        state   <= ST_COLLECT;
                        cnt     <= 2'd1;
                        win_cnt <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (key_pulse) begin
                        cnt     <= cnt_inc;
                        win_cnt <= '0;
                        if (emit_max) begin
                            state <= ST_IDLE;
                        end
                    end else if (timeout) begin
                        state <= ST_IDLE;
                    end else begin
                        win_cnt <= win_cnt + 20'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered event outputs; click_cnt holds between events.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            click_valid <= 1'b0;
            click_cnt   <= '0;
        end else begin
            click_valid <= emit;
            if (emit) begin
                click_cnt <= emit_cnt;
            end
        end
    end

endmodule
